board_io: RTL and testbench

Parametrised board-level I/O conditioner between raw FPGA pins and the MCU core in each board wrapper. It debounces N push-buttons with edge pulses, drives N LEDs from activity sources with per-LED mode (direct, inverted, pulse-stretched, off), and sequences a delayed MCU reset release. It replaces the fixed, combinational LED/switch wiring and two-flop reset of earlier board tops.

---
 rtl/board_io.sv | 187 ++++++++++++++++++
 tb/tb_board_io.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io.sv
// board_io: board-level I/O conditioner between raw FPGA pins and the MCU core.
//
// Purpose:
//   - Debounces N_SW active-low push-buttons and emits one-cycle edge pulses.
//   - Drives N_LED LEDs from asynchronous activity sources, each with a
//     selectable mode (direct, inverted, pulse-stretched, off).
//   - Holds the MCU in reset for RST_CYCLES cycles after i_rst deasserts.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_sw_in      raw asynchronous switch pins
//   o_sw_db      debounced switch levels
//   o_sw_rise    one-cycle pulse when o_sw_db goes 0->1
//   o_sw_fall    one-cycle pulse when o_sw_db goes 1->0
//   i_led_src    asynchronous LED activity sources
//   i_led_mode   per-LED mode, bits [2i+1:2i]: 00 direct, 01 inverted, 10 stretch, 11 off
//   o_led_out    registered LED drive
//   o_mcu_rst_n  active-low MCU reset, released after the delay
module board_io #(
  parameter int unsigned       N_SW          = 4,
  parameter int unsigned       N_LED         = 8,
  parameter logic              SW_IDLE       = 1'b1,
  parameter logic [N_LED-1:0]  LED_IDLE      = {N_LED{1'b0}},
  parameter int unsigned       DEBOUNCE_BITS = 16,
  parameter int unsigned       STRETCH_BITS  = 22,
  parameter int unsigned       RST_CYCLES    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_SW-1:0]    i_sw_in,
  output logic [N_SW-1:0]    o_sw_db,
  output logic [N_SW-1:0]    o_sw_rise,
  output logic [N_SW-1:0]    o_sw_fall,
  input  logic [N_LED-1:0]   i_led_src,
  input  logic [2*N_LED-1:0] i_led_mode,
  output logic [N_LED-1:0]   o_led_out,
  output logic               o_mcu_rst_n
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

  localparam logic [DEBOUNCE_BITS-1:0] DB_ONE  = DEBOUNCE_BITS'(1);
  localparam logic [STRETCH_BITS-1:0]  STR_ONE = STRETCH_BITS'(1);
  localparam logic [RST_W-1:0]         RST_ONE = RST_W'(1);
  localparam logic [RST_W-1:0]         RST_MAX = RST_W'(RST_CYCLES);

  // ---------------------------------------------------------------------------
  // Switch path: 2-flop synchroniser then debounce
  // ---------------------------------------------------------------------------
  logic [N_SW-1:0]          r_sw_meta;
  logic [N_SW-1:0]          r_sw_sync;
  logic [N_SW-1:0]          r_sw_db;
  logic [N_SW-1:0]          r_sw_rise;
  logic [N_SW-1:0]          r_sw_fall;
  logic [DEBOUNCE_BITS-1:0] r_db_cnt [N_SW];

  logic [N_SW-1:0]          w_sw_db_d;
  logic [N_SW-1:0]          w_sw_rise_d;
  logic [N_SW-1:0]          w_sw_fall_d;
  logic [DEBOUNCE_BITS-1:0] w_db_cnt_d [N_SW];

  always_comb begin
    for (int i = 0; i < int'(N_SW); i++) begin
      w_sw_db_d[i]   = r_sw_db[i];
      w_sw_rise_d[i] = 1'b0;
      w_sw_fall_d[i] = 1'b0;
      w_db_cnt_d[i]  = r_db_cnt[i];
      if (r_sw_sync[i] == r_sw_db[i]) begin
        // Any return to the accepted level restarts the acceptance period.
        w_db_cnt_d[i] = '0;
      end else if (&r_db_cnt[i]) begin
        w_sw_db_d[i]   = r_sw_sync[i];
        w_sw_rise_d[i] = r_sw_sync[i];
        w_sw_fall_d[i] = ~r_sw_sync[i];
        w_db_cnt_d[i]  = '0;
      end else begin
        w_db_cnt_d[i] = r_db_cnt[i] + DB_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sw_meta <= {N_SW{SW_IDLE}};
      r_sw_sync <= {N_SW{SW_IDLE}};
      r_sw_db   <= {N_SW{SW_IDLE}};
      r_sw_rise <= '0;
      r_sw_fall <= '0;
      for (int i = 0; i < int'(N_SW); i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sw_meta <= i_sw_in;
      r_sw_sync <= r_sw_meta;
      r_sw_db   <= w_sw_db_d;
      r_sw_rise <= w_sw_rise_d;
      r_sw_fall <= w_sw_fall_d;
      for (int i = 0; i < int'(N_SW); i++) begin
        r_db_cnt[i] <= w_db_cnt_d[i];
      end
    end
  end

  assign o_sw_db   = r_sw_db;
  assign o_sw_rise = r_sw_rise;
  assign o_sw_fall = r_sw_fall;

  // ---------------------------------------------------------------------------
  // LED path: 2-flop synchroniser, edge-detect flop, stretch counter, output reg
  // ---------------------------------------------------------------------------
  logic [N_LED-1:0]        r_led_meta;
  logic [N_LED-1:0]        r_led_sync;
  logic [N_LED-1:0]        r_led_prev;
  logic [N_LED-1:0]        r_led_out;
  logic [STRETCH_BITS-1:0] r_str_cnt [N_LED];

  logic [N_LED-1:0]        w_led_edge;
  logic [N_LED-1:0]        w_led_out_d;
  logic [STRETCH_BITS-1:0] w_str_cnt_d [N_LED];

  assign w_led_edge = r_led_sync ^ r_led_prev;

  always_comb begin
    for (int i = 0; i < int'(N_LED); i++) begin
      // Counter runs in every mode so switching to stretch shows recent activity.
      w_str_cnt_d[i] = r_str_cnt[i];
      if (w_led_edge[i]) begin
        w_str_cnt_d[i] = '1;
      end else if (r_str_cnt[i] != '0) begin
        w_str_cnt_d[i] = r_str_cnt[i] - STR_ONE;
      end

      w_led_out_d[i] = 1'b0;
      unique case (i_led_mode[2*i +: 2])
        2'b00:   w_led_out_d[i] = r_led_sync[i];
        2'b01:   w_led_out_d[i] = ~r_led_sync[i];
        2'b10:   w_led_out_d[i] = (r_str_cnt[i] != '0);
        default: w_led_out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_led_meta <= LED_IDLE;
      r_led_sync <= LED_IDLE;
      r_led_prev <= LED_IDLE;
      r_led_out  <= '0;
      for (int i = 0; i < int'(N_LED); i++) begin
        r_str_cnt[i] <= '0;
      end
    end else begin
      r_led_meta <= i_led_src;
      r_led_sync <= r_led_meta;
      r_led_prev <= r_led_sync;
      r_led_out  <= w_led_out_d;
      for (int i = 0; i < int'(N_LED); i++) begin
        r_str_cnt[i] <= w_str_cnt_d[i];
      end
    end
  end

  assign o_led_out = r_led_out;

  // ---------------------------------------------------------------------------
  // MCU reset sequencer
  // ---------------------------------------------------------------------------
  logic [RST_W-1:0] r_rst_cnt;
  logic             r_mcu_rst_n;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rst_cnt   <= '0;
      r_mcu_rst_n <= 1'b0;
    end else begin
      if (r_rst_cnt < RST_MAX) begin
        r_rst_cnt <= r_rst_cnt + RST_ONE;
      end
      // Registered compare adds the final edge of the RST_CYCLES+1 delay.
      r_mcu_rst_n <= (r_rst_cnt == RST_MAX);
    end
  end

  assign o_mcu_rst_n = r_mcu_rst_n;

endmodule

// File: tb/tb_board_io.sv
// tb_board_io: self-checking bench for board_io.
// Reference model works from pin histories: synchronised values are delayed pin
// samples, debounce acceptance is "last 2^DEBOUNCE_BITS synchronised samples all
// differ from the accepted level", stretch is "an edge within the last
// 2^STRETCH_BITS-1 cycles", and MCU release is "no reset in the last RST_CYCLES+1 edges".
module tb_board_io;

  localparam int unsigned      N_SW   = 4;
  localparam int unsigned      N_LED  = 8;
  localparam logic             SWI_B  = 1'b1;
  localparam logic [N_LED-1:0] LEDI   = 8'h10;
  localparam int unsigned      DB     = 2;
  localparam int unsigned      STR    = 3;
  localparam int unsigned      RSTC   = 4;
  localparam int               DB_WIN = 1 << DB;
  localparam int               STR_HI = (1 << STR) - 1;
  localparam int               HMAX   = 4096;
  localparam logic [N_SW-1:0]  SWI    = {N_SW{SWI_B}};

  logic               clk = 1'b0;
  logic               rst;
  logic [N_SW-1:0]    sw;
  logic [N_LED-1:0]   led;
  logic [2*N_LED-1:0] mode;
  logic [N_SW-1:0]    sw_db, sw_rise, sw_fall;
  logic [N_LED-1:0]   led_out;
  logic               mcu_rst_n;

  board_io #(
    .N_SW(N_SW), .N_LED(N_LED), .SW_IDLE(SWI_B), .LED_IDLE(LEDI),
    .DEBOUNCE_BITS(DB), .STRETCH_BITS(STR), .RST_CYCLES(RSTC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_in(sw), .o_sw_db(sw_db), .o_sw_rise(sw_rise),
    .o_sw_fall(sw_fall), .i_led_src(led), .i_led_mode(mode), .o_led_out(led_out),
    .o_mcu_rst_n(mcu_rst_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  // Histories indexed by edge number.
  logic             rst_h     [HMAX];
  logic [N_SW-1:0]  sw_h      [HMAX];
  logic [N_LED-1:0] led_h     [HMAX];
  logic [N_SW-1:0]  swsync_h  [HMAX];
  logic [N_LED-1:0] ledsync_h [HMAX];
  logic [N_LED-1:0] ledprev_h [HMAX];

  logic [N_SW-1:0]  exp_db, exp_rise, exp_fall;
  logic [N_LED-1:0] exp_led;
  logic             exp_mcu;

  function automatic logic f_load(int j, int i);
    logic [N_LED-1:0] s, p;
    if (j < 2 || rst_h[j]) return 1'b0;
    s = ledsync_h[j-1];
    p = ledprev_h[j-1];
    return s[i] != p[i];
  endfunction

  // Stretch counter nonzero after edge m.
  function automatic logic f_str_on(int m, int i);
    for (int j = m; j >= m - (STR_HI - 1); j--) begin
      if (j < 2) return 1'b0;
      if (f_load(j, i)) return 1'b1;
      if (rst_h[j]) return 1'b0;
    end
    return 1'b0;
  endfunction

  task automatic step();
    logic [N_SW-1:0]  s;
    logic [N_LED-1:0] ls;
    logic             acc;
    k++;
    if (k >= HMAX) begin
      $display("FAIL history: edge %0d exceeds %0d", k, HMAX);
      $fatal(1);
    end
    rst_h[k] = rst;
    sw_h[k]  = sw;
    led_h[k] = led;
    @(posedge clk);
    #1;
    swsync_h[k]  = (rst_h[k] || rst_h[k-1]) ? SWI : sw_h[k-1];
    ledsync_h[k] = (rst_h[k] || rst_h[k-1]) ? LEDI : led_h[k-1];
    ledprev_h[k] = rst_h[k] ? LEDI : ledsync_h[k-1];
    if (rst_h[k]) begin
      exp_db = SWI; exp_rise = '0; exp_fall = '0; exp_led = '0;
    end else begin
      exp_rise = '0;
      exp_fall = '0;
      for (int b = 0; b < int'(N_SW); b++) begin
        acc = (k > DB_WIN);
        for (int j = k - DB_WIN; j < k; j++) begin
          if (j >= 0) begin
            s = swsync_h[j];
            if (s[b] == exp_db[b]) acc = 1'b0;
          end
        end
        if (acc) begin
          exp_rise[b] = ~exp_db[b];
          exp_fall[b] = exp_db[b];
          exp_db[b]   = ~exp_db[b];
        end
      end
      ls = ledsync_h[k-1];
      for (int i = 0; i < int'(N_LED); i++) begin
        case (mode[2*i +: 2])
          2'b00:   exp_led[i] = ls[i];
          2'b01:   exp_led[i] = ~ls[i];
          2'b10:   exp_led[i] = f_str_on(k - 1, i);
          default: exp_led[i] = 1'b0;
        endcase
      end
    end
    exp_mcu = (k >= int'(RSTC));
    for (int j = k - int'(RSTC); j <= k; j++) begin
      if (j < 0 || rst_h[j]) exp_mcu = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (sw_db !== SWI || sw_rise !== '0 || sw_fall !== '0 || led_out !== '0 ||
          mcu_rst_n !== 1'b0) begin
        n_err++;
        $display("FAIL reset_values: db=%h rise=%h fall=%h led=%h mcu=%b required %h/0/0/0/0",
                 sw_db, sw_rise, sw_fall, led_out, mcu_rst_n, SWI);
      end
    end
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      n++;
      n_cmp++;
      if (mcu_rst_n !== exp_mcu) begin
        n_err++;
        $display("FAIL mcu_model: edge %0d got %b required %b", n, mcu_rst_n, exp_mcu);
      end
      if (mcu_rst_n === 1'b1) break;
    end
    n_cmp++;
    if (n != int'(RSTC) + 1) begin
      n_err++;
      $display("FAIL mcu_release_delay: got %0d edges required %0d", n, RSTC + 1);
    end
    // Restart: rst sampled at edge 2 of the count.
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (mcu_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL mcu_reassert: got %b required 0", mcu_rst_n);
    end
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      n++;
      if (mcu_rst_n === 1'b1) break;
    end
    n_cmp++;
    if (n != int'(RSTC) + 1) begin
      n_err++;
      $display("FAIL mcu_restart_delay: got %0d edges required %0d", n, RSTC + 1);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (mcu_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL mcu_drop_after_release: got %b required 0", mcu_rst_n);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) step();
  endtask

  task automatic test_sw_accept();
    int n;
    int falls;
    sw = SWI;
    for (int c = 0; c < 8; c++) step();
    sw[0] = 1'b0;
    n = 0;
    falls = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      n++;
      n_cmp++;
      if (sw_rise !== '0 || sw_fall[3:1] !== 3'b000 || sw_db[3:1] !== 3'b111) begin
        n_err++;
        $display("FAIL sw0_quiet_others: rise=%h fall=%h db=%h required 0/0xx0/111x",
                 sw_rise, sw_fall, sw_db);
      end
      if (sw_fall[0]) falls++;
      if (sw_db[0] === 1'b0) break;
    end
    n_cmp++;
    if (n != 2 + DB_WIN || falls != 1 || sw_fall[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sw0_accept_latency: got %0d cycles falls=%0d required %0d cycles 1 fall",
               n, falls, 2 + DB_WIN);
    end
    step();
    n_cmp++;
    if (sw_fall[0] !== 1'b0 || sw_db[0] !== 1'b0) begin
      n_err++;
      $display("FAIL sw0_pulse_width: fall=%b db=%b required 0/0", sw_fall[0], sw_db[0]);
    end
  endtask

  task automatic test_sw_glitch();
    sw[1] = 1'b0;
    for (int c = 0; c < 3; c++) step();
    sw[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (sw_db[1] !== 1'b1 || sw_fall[1] !== 1'b0 || sw_rise[1] !== 1'b0) begin
        n_err++;
        $display("FAIL sw1_glitch_rejected: db=%b rise=%b fall=%b required 1/0/0",
                 sw_db[1], sw_rise[1], sw_fall[1]);
      end
    end
    sw[1] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      n_cmp++;
      if (sw_db[1] !== (c < 6 ? 1'b1 : 1'b0) || sw_fall[1] !== (c == 6)) begin
        n_err++;
        $display("FAIL sw1_accept: cycle %0d db=%b fall=%b required %b/%b",
                 c, sw_db[1], sw_fall[1], c < 6, c == 6);
      end
    end
    sw = SWI;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (sw_db !== exp_db || sw_rise !== exp_rise || sw_fall !== exp_fall) begin
        n_err++;
        $display("FAIL sw_release_model: db=%h rise=%h fall=%h required %h/%h/%h",
                 sw_db, sw_rise, sw_fall, exp_db, exp_rise, exp_fall);
      end
    end
  endtask

  task automatic test_stretch();
    int first, cnt;
    mode = '0;
    mode[1:0] = 2'b10;
    led = LEDI;
    for (int c = 0; c < 12; c++) step();
    // Single edge: 7 cycles high, starting 4 cycles after it.
    led[0] = 1'b1;
    first = 0;
    cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (led_out[0]) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    n_cmp++;
    if (first != 4 || cnt != STR_HI) begin
      n_err++;
      $display("FAIL stretch_single: first=%0d count=%0d required 4/%0d", first, cnt, STR_HI);
    end
    // Second edge 3 cycles into the stretch extends it.
    led[0] = 1'b0;
    for (int c = 0; c < 12; c++) step();
    led[0] = 1'b1;
    first = 0;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) led[0] = 1'b0;
      step();
      if (led_out[0]) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    n_cmp++;
    if (first != 4 || cnt != 3 + STR_HI) begin
      n_err++;
      $display("FAIL stretch_retrigger: first=%0d count=%0d required 4/%0d",
               first, cnt, 3 + STR_HI);
    end
    // One-cycle pulse checked against the model.
    led[0] = 1'b1;
    step();
    led[0] = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step();
      n_cmp++;
      if (led_out[0] !== exp_led[0]) begin
        n_err++;
        $display("FAIL stretch_pulse_model: cycle %0d got %b required %b",
                 c, led_out[0], exp_led[0]);
      end
    end
  endtask

  task automatic test_led_modes();
    logic [N_LED-1:0] hist [4];
    mode = '0;
    mode[3:2] = 2'b00;
    mode[5:4] = 2'b01;
    mode[7:6] = 2'b11;
    for (int c = 0; c < 40; c++) begin
      led[3:1] = 3'($urandom);
      hist[c % 4] = led;
      step();
      n_cmp++;
      if (led_out[3:1] !== exp_led[3:1]) begin
        n_err++;
        $display("FAIL led_modes_model: got %b required %b", led_out[3:1], exp_led[3:1]);
      end
      if (c >= 3) begin
        n_cmp++;
        if (led_out[1] !== hist[(c - 2) % 4][1] || led_out[2] !== ~hist[(c - 2) % 4][2] ||
            led_out[3] !== 1'b0) begin
          n_err++;
          $display("FAIL led_modes_latency: got %b required %b%b0", led_out[3:1],
                   ~hist[(c - 2) % 4][2], hist[(c - 2) % 4][1]);
        end
      end
    end
  endtask

  task automatic test_led_idle();
    mode = '0;
    mode[9:8] = 2'b10;
    led = LEDI;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++;
      if (led_out[4] !== 1'b0 || led_out !== exp_led) begin
        n_err++;
        $display("FAIL led_idle_dark: got %h required %h with bit4 0", led_out, exp_led);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < int'(N_SW); b++) begin
        if ($urandom_range(5) == 0) sw[b] = ~sw[b];
      end
      for (int i = 0; i < int'(N_LED); i++) begin
        if ($urandom_range(6) == 0) led[i] = ~led[i];
      end
      if ($urandom_range(40) == 0) mode = 16'($urandom);
      rst = ($urandom_range(200) == 0);
      step();
      n_cmp++;
      if (sw_db !== exp_db || sw_rise !== exp_rise || sw_fall !== exp_fall ||
          led_out !== exp_led || mcu_rst_n !== exp_mcu) begin
        n_err++;
        $display("FAIL random_model: edge %0d got %h/%h/%h/%h/%b required %h/%h/%h/%h/%b",
                 k, sw_db, sw_rise, sw_fall, led_out, mcu_rst_n,
                 exp_db, exp_rise, exp_fall, exp_led, exp_mcu);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw = SWI;
    led = LEDI;
    mode = '0;
    rst_h[0] = 1'b1;
    sw_h[0] = SWI;
    led_h[0] = LEDI;
    swsync_h[0] = SWI;
    ledsync_h[0] = LEDI;
    ledprev_h[0] = LEDI;
    exp_db = SWI;
    exp_rise = '0;
    exp_fall = '0;
    exp_led = '0;
    exp_mcu = 1'b0;
    #2;
    test_reset();
    test_sw_accept();
    test_sw_glitch();
    test_stretch();
    test_led_modes();
    test_led_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
